// File: rtl/axi_spi_flash_reader.sv
// AXI4 slave that serves read bursts from a serial SPI flash using the plain read opcode.
// The write path is a stub that accepts one AW and its W burst, then answers SLVERR.
//
// state | meaning
// IDLE  | waiting for an AR; ar_ready high
// CMD   | shifting the read opcode out on dq_0
// ADDR  | shifting the 24-bit flash address out on dq_0
// DATA  | shifting 32 bits of one beat in from dq_1
// RESP  | presenting the beat on R; sck parked low
// GAP   | cs deasserted for the minimum deselect time
`timescale 1ns/1ps
module axi_spi_flash_reader #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          ID_WIDTH   = 4,
  parameter int          SCK_DIV    = 2,
  parameter logic [7:0]  READ_CMD   = 8'h03
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_s_axi_aw_valid,
  output logic                  io_s_axi_aw_ready,
  input  logic [ID_WIDTH-1:0]   io_s_axi_aw_bits_id,
  input  logic [ADDR_WIDTH-1:0] io_s_axi_aw_bits_addr,
  input  logic [7:0]            io_s_axi_aw_bits_len,
  input  logic [2:0]            io_s_axi_aw_bits_size,
  input  logic [1:0]            io_s_axi_aw_bits_burst,
  input  logic                  io_s_axi_w_valid,
  output logic                  io_s_axi_w_ready,
  input  logic [31:0]           io_s_axi_w_bits_data,
  input  logic [3:0]            io_s_axi_w_bits_strb,
  input  logic                  io_s_axi_w_bits_last,
  output logic                  io_s_axi_b_valid,
  input  logic                  io_s_axi_b_ready,
  output logic [ID_WIDTH-1:0]   io_s_axi_b_bits_id,
  output logic [1:0]            io_s_axi_b_bits_resp,
  input  logic                  io_s_axi_ar_valid,
  output logic                  io_s_axi_ar_ready,
  input  logic [ID_WIDTH-1:0]   io_s_axi_ar_bits_id,
  input  logic [ADDR_WIDTH-1:0] io_s_axi_ar_bits_addr,
  input  logic [7:0]            io_s_axi_ar_bits_len,
  input  logic [2:0]            io_s_axi_ar_bits_size,
  input  logic [1:0]            io_s_axi_ar_bits_burst,
  output logic                  io_s_axi_r_valid,
  input  logic                  io_s_axi_r_ready,
  output logic [ID_WIDTH-1:0]   io_s_axi_r_bits_id,
  output logic [31:0]           io_s_axi_r_bits_data,
  output logic [1:0]            io_s_axi_r_bits_resp,
  output logic                  io_s_axi_r_bits_last,
  output logic                  io_qspi_cs,
  output logic                  io_qspi_sck,
  output logic                  io_qspi_dq_0,
  input  logic                  io_qspi_dq_1
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;

  localparam int DW = $clog2(2 * SCK_DIV + 1);
  localparam logic [DW-1:0] HALF_LD = DW'(SCK_DIV - 1);
  localparam logic [DW-1:0] GAP_LD  = DW'(2 * SCK_DIV - 1);

  logic [2:0]          state_q, state_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          beat_q, beat_d;
  logic [DW-1:0]       div_q, div_d;
  logic [4:0]          bit_q, bit_d;
  logic                sck_q, sck_d;
  logic                cs_q, cs_d;
  logic [31:0]         shift_q, shift_d;
  logic [31:0]         rx_q, rx_d;
  logic                r_valid_q, r_valid_d;
  logic [31:0]         r_data_q, r_data_d;
  logic                r_last_q, r_last_d;
  logic [ID_WIDTH-1:0] r_id_q, r_id_d;
  logic                live_q, live_d;
  logic                aw_got_q, aw_got_d;
  logic                w_got_q, w_got_d;
  logic                b_valid_q, b_valid_d;
  logic [ID_WIDTH-1:0] awid_q, awid_d;

  logic ar_hs, aw_hs, w_hs, tick;
  logic unused_inputs;

  assign unused_inputs = ^{io_s_axi_aw_bits_addr, io_s_axi_aw_bits_len, io_s_axi_aw_bits_size,
                           io_s_axi_aw_bits_burst, io_s_axi_w_bits_data, io_s_axi_w_bits_strb,
                           io_s_axi_ar_bits_addr[ADDR_WIDTH-1:24], io_s_axi_ar_bits_size,
                           io_s_axi_ar_bits_burst};

  // live_q keeps every ready low while reset is held and lifts them on the first edge after.
  assign live_d            = 1'b1;
  assign io_s_axi_ar_ready = live_q && (state_q == S_IDLE);
  assign io_s_axi_aw_ready = live_q && !aw_got_q && !b_valid_q;
  assign io_s_axi_w_ready  = live_q && !w_got_q && !b_valid_q;
  assign ar_hs = io_s_axi_ar_valid && io_s_axi_ar_ready;
  assign aw_hs = io_s_axi_aw_valid && io_s_axi_aw_ready;
  assign w_hs  = io_s_axi_w_valid && io_s_axi_w_ready;
  assign tick  = (div_q == '0);

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    len_d     = len_q;
    beat_d    = beat_q;
    div_d     = div_q;
    bit_d     = bit_q;
    sck_d     = sck_q;
    cs_d      = cs_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_last_d  = r_last_q;
    r_id_d    = r_id_q;
    case (state_q)
      S_IDLE: begin
        if (ar_hs) begin
          state_d = S_CMD;
          id_d    = io_s_axi_ar_bits_id;
          len_d   = io_s_axi_ar_bits_len;
          beat_d  = 8'd0;
          cs_d    = 1'b0;
          sck_d   = 1'b0;
          bit_d   = 5'd0;
          div_d   = HALF_LD;
          shift_d = {READ_CMD, io_s_axi_ar_bits_addr[23:0]};
        end
      end
      S_CMD, S_ADDR, S_DATA: begin
        if (!tick) begin
          div_d = div_q - DW'(1);
        end else begin
          div_d = HALF_LD;
          sck_d = ~sck_q;
          if (!sck_q) begin
            if (state_q == S_DATA) rx_d = {rx_q[30:0], io_qspi_dq_1};
          end else begin
            // Falling edge: the next outgoing bit appears while sck is low.
            shift_d = {shift_q[30:0], 1'b0};
            bit_d   = bit_q + 5'd1;
            if (state_q == S_CMD && bit_q == 5'd7) state_d = S_ADDR;
            if (state_q == S_ADDR && bit_q == 5'd31) begin
              state_d = S_DATA;
              bit_d   = 5'd0;
            end
            if (state_q == S_DATA && bit_q == 5'd31) begin
              state_d   = S_RESP;
              bit_d     = 5'd0;
              r_valid_d = 1'b1;
              r_data_d  = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
              r_last_d  = (beat_q == len_q);
              r_id_d    = id_q;
            end
          end
        end
      end
      S_RESP: begin
        if (io_s_axi_r_ready) begin
          r_valid_d = 1'b0;
          if (r_last_q) begin
            state_d = S_GAP;
            cs_d    = 1'b1;
            div_d   = GAP_LD;
          end else begin
            state_d = S_DATA;
            beat_d  = beat_q + 8'd1;
            div_d   = HALF_LD;
          end
        end
      end
      S_GAP: begin
        if (tick) state_d = S_IDLE;
        else      div_d   = div_q - DW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    aw_got_d  = aw_got_q | aw_hs;
    w_got_d   = w_got_q | (w_hs && io_s_axi_w_bits_last);
    awid_d    = aw_hs ? io_s_axi_aw_bits_id : awid_q;
    b_valid_d = b_valid_q;
    if (b_valid_q && io_s_axi_b_ready) begin
      b_valid_d = 1'b0;
      aw_got_d  = 1'b0;
      w_got_d   = 1'b0;
    end else if (aw_got_d && w_got_d) begin
      b_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      shift_q   <= '0;
      rx_q      <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_last_q  <= 1'b0;
      r_id_q    <= '0;
      live_q    <= 1'b0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      b_valid_q <= 1'b0;
      awid_q    <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      sck_q     <= sck_d;
      cs_q      <= cs_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_last_q  <= r_last_d;
      r_id_q    <= r_id_d;
      live_q    <= live_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      b_valid_q <= b_valid_d;
      awid_q    <= awid_d;
    end
  end

  assign io_qspi_cs           = cs_q;
  assign io_qspi_sck          = sck_q;
  assign io_qspi_dq_0         = shift_q[31];
  assign io_s_axi_r_valid     = r_valid_q;
  assign io_s_axi_r_bits_id   = r_id_q;
  assign io_s_axi_r_bits_data = r_data_q;
  assign io_s_axi_r_bits_resp = 2'b00;
  assign io_s_axi_r_bits_last = r_last_q;
  assign io_s_axi_b_valid     = b_valid_q;
  assign io_s_axi_b_bits_id   = awid_q;
  assign io_s_axi_b_bits_resp = 2'b10;

endmodule

// File: tb/tb_axi_spi_flash_reader.sv
// Scoreboard bench: directed AXI traffic against a serial flash model holding byte[i] = i & 0xFF.
`timescale 1ns/1ps
module tb_axi_spi_flash_reader;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        aw_valid = 0, aw_ready;
  logic [3:0]  aw_id = 0;
  logic [31:0] aw_addr = 0;
  logic [7:0]  aw_len = 0;
  logic [2:0]  aw_size = 3'd2;
  logic [1:0]  aw_burst = 2'b01;
  logic        w_valid = 0, w_ready;
  logic [31:0] w_data = 0;
  logic [3:0]  w_strb = 4'hF;
  logic        w_last = 0;
  logic        b_valid, b_ready = 1;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic        ar_valid = 0, ar_ready;
  logic [3:0]  ar_id = 0;
  logic [31:0] ar_addr = 0;
  logic [7:0]  ar_len = 0;
  logic [2:0]  ar_size = 3'd2;
  logic [1:0]  ar_burst = 2'b01;
  logic        r_valid, r_ready = 1;
  logic [3:0]  r_id;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        cs, sck, dq_0;
  logic        dq_1 = 1'b0;

  axi_spi_flash_reader #(.ADDR_WIDTH(32), .ID_WIDTH(4), .SCK_DIV(2), .READ_CMD(8'h03)) dut (
    .clock(clock), .reset(reset),
    .io_s_axi_aw_valid(aw_valid), .io_s_axi_aw_ready(aw_ready), .io_s_axi_aw_bits_id(aw_id),
    .io_s_axi_aw_bits_addr(aw_addr), .io_s_axi_aw_bits_len(aw_len), .io_s_axi_aw_bits_size(aw_size),
    .io_s_axi_aw_bits_burst(aw_burst),
    .io_s_axi_w_valid(w_valid), .io_s_axi_w_ready(w_ready), .io_s_axi_w_bits_data(w_data),
    .io_s_axi_w_bits_strb(w_strb), .io_s_axi_w_bits_last(w_last),
    .io_s_axi_b_valid(b_valid), .io_s_axi_b_ready(b_ready), .io_s_axi_b_bits_id(b_id),
    .io_s_axi_b_bits_resp(b_resp),
    .io_s_axi_ar_valid(ar_valid), .io_s_axi_ar_ready(ar_ready), .io_s_axi_ar_bits_id(ar_id),
    .io_s_axi_ar_bits_addr(ar_addr), .io_s_axi_ar_bits_len(ar_len), .io_s_axi_ar_bits_size(ar_size),
    .io_s_axi_ar_bits_burst(ar_burst),
    .io_s_axi_r_valid(r_valid), .io_s_axi_r_ready(r_ready), .io_s_axi_r_bits_id(r_id),
    .io_s_axi_r_bits_data(r_data), .io_s_axi_r_bits_resp(r_resp), .io_s_axi_r_bits_last(r_last),
    .io_qspi_cs(cs), .io_qspi_sck(sck), .io_qspi_dq_0(dq_0), .io_qspi_dq_1(dq_1)
  );

  typedef struct packed {logic [3:0] id; logic [31:0] data; logic last;} r_exp_t;
  typedef struct packed {logic [3:0] id; logic [1:0] resp;} b_exp_t;
  r_exp_t r_q[$];
  b_exp_t b_q[$];
  r_exp_t r_e;
  b_exp_t b_e;

  int tests = 0;
  int fails = 0;
  int cmd_cnt = 0;
  logic [23:0] exp_fa = 24'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out, expected event did not occur", name);
  endtask

  // Flash model: receives opcode+address on dq_0, then streams bytes MSB first.
  int          mbits = 0;
  int          mdbit = 0;
  logic [31:0] mcmdaddr = 0;
  logic [23:0] mptr = 0;
  logic [7:0]  mbyte;

  always @(negedge cs) begin
    mbits = 0;
    mdbit = 0;
  end

  always @(posedge sck) begin
    if (!cs && mbits < 32) begin
      mcmdaddr = {mcmdaddr[30:0], dq_0};
      mbits++;
    end
  end

  always @(negedge sck) begin
    if (!cs) begin
      if (mbits == 32) begin
        check("flash_cmd", {24'h0, mcmdaddr[31:24]}, 32'h03);
        check("flash_addr", {8'h0, mcmdaddr[23:0]}, {8'h0, exp_fa});
        cmd_cnt++;
        mptr  = mcmdaddr[23:0];
        mdbit = 0;
        mbits = 33;
      end else if (mbits == 33) begin
        mdbit++;
        if (mdbit == 8) begin
          mdbit = 0;
          mptr  = mptr + 24'd1;
        end
      end
      mbyte = mptr[7:0];
      dq_1  = (mbits == 33) ? mbyte[7 - mdbit] : 1'b0;
    end
  end

  always @(negedge clock) begin
    if (reset && r_valid && r_ready) begin
      if (r_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL r_unexpected: got data 0x%08h, expected no response", r_data);
      end else begin
        r_e = r_q.pop_front();
        check("r_data", r_data, r_e.data);
        check("r_id", {28'h0, r_id}, {28'h0, r_e.id});
        check("r_last", {31'h0, r_last}, {31'h0, r_e.last});
        check("r_resp", {30'h0, r_resp}, 32'h0);
      end
    end
  end

  always @(negedge clock) begin
    if (reset && b_valid && b_ready) begin
      if (b_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_unexpected: got id %0d, expected no response", b_id);
      end else begin
        b_e = b_q.pop_front();
        check("b_id", {28'h0, b_id}, {28'h0, b_e.id});
        check("b_resp", {30'h0, b_resp}, {30'h0, b_e.resp});
      end
    end
  end

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    bit got = 0;
    @(posedge clock);
    #1;
    ar_valid = 1; ar_id = id; ar_addr = addr; ar_len = len;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (ar_ready) begin got = 1; break; end
    end
    if (!got) timeout("ar_handshake");
    @(posedge clock);
    #1 ar_valid = 0;
  endtask

  task automatic push_r(input logic [3:0] id, input logic [31:0] data, input logic last);
    r_exp_t e;
    e.id = id; e.data = data; e.last = last;
    r_q.push_back(e);
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clock);
      if (r_q.size() == 0 && b_q.size() == 0) begin done = 1; break; end
    end
    if (!done) timeout("drain_responses");
    repeat (10) @(negedge clock);
  endtask

  task automatic wait_rvalid();
    bit got = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (r_valid) begin got = 1; break; end
    end
    if (!got) timeout("r_valid_wait");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int c0;
    bit ended;
    b_exp_t be;

    #12;
    check("rst_cs", {31'h0, cs}, 32'h1);
    check("rst_sck", {31'h0, sck}, 32'h0);
    check("rst_dq0", {31'h0, dq_0}, 32'h0);
    check("rst_ar_ready", {31'h0, ar_ready}, 32'h0);
    check("rst_aw_ready", {31'h0, aw_ready}, 32'h0);
    check("rst_w_ready", {31'h0, w_ready}, 32'h0);
    check("rst_r_valid", {31'h0, r_valid}, 32'h0);
    check("rst_b_valid", {31'h0, b_valid}, 32'h0);
    check("rst_r_data", r_data, 32'h0);
    @(negedge clock);
    reset = 1;
    @(posedge clock);
    #1;
    check("rel_ar_ready", {31'h0, ar_ready}, 32'h1);
    check("rel_aw_ready", {31'h0, aw_ready}, 32'h1);
    check("rel_w_ready", {31'h0, w_ready}, 32'h1);

    // Single read at flash address 0 with cs window measured.
    exp_fa = 24'h000000;
    c0 = cmd_cnt;
    push_r(4'd0, 32'h03020100, 1'b1);
    ar_send(4'd0, 32'h2000_0000, 8'd0);
    cnt = 0;
    ended = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (cs) begin ended = 1; break; end
      cnt++;
    end
    if (!ended) timeout("cs_release");
    check("cs_low_cycles", cnt, 32'd257);
    wait_drain();
    check("single_cmd_phases", cmd_cnt - c0, 32'd1);

    exp_fa = 24'h000004;
    push_r(4'd1, 32'h07060504, 1'b1);
    ar_send(4'd1, 32'h2000_0004, 8'd0);
    wait_drain();

    // Four-beat burst, one command phase.
    exp_fa = 24'h000010;
    c0 = cmd_cnt;
    push_r(4'd2, 32'h13121110, 1'b0);
    push_r(4'd2, 32'h17161514, 1'b0);
    push_r(4'd2, 32'h1B1A1918, 1'b0);
    push_r(4'd2, 32'h1F1E1D1C, 1'b1);
    ar_send(4'd2, 32'h0000_0010, 8'd3);
    wait_drain();
    check("burst_cmd_phases", cmd_cnt - c0, 32'd1);

    // Same burst with a 20-cycle stall on the second beat.
    r_ready = 0;
    exp_fa = 24'h000010;
    push_r(4'd3, 32'h13121110, 1'b0);
    push_r(4'd3, 32'h17161514, 1'b0);
    push_r(4'd3, 32'h1B1A1918, 1'b0);
    push_r(4'd3, 32'h1F1E1D1C, 1'b1);
    ar_send(4'd3, 32'h0000_0010, 8'd3);
    for (int beat = 0; beat < 4; beat++) begin
      wait_rvalid();
      if (beat == 1) begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clock);
          check("stall_r_data", r_data, 32'h17161514);
          check("stall_r_valid", {31'h0, r_valid}, 32'h1);
          check("stall_sck", {31'h0, sck}, 32'h0);
          check("stall_cs", {31'h0, cs}, 32'h0);
        end
      end
      @(posedge clock);
      #1 r_ready = 1;
      @(posedge clock);
      #1 r_ready = 0;
    end
    wait_drain();
    r_ready = 1;

    // Write rejected with SLVERR while a read runs alongside.
    exp_fa = 24'h000040;
    push_r(4'd3, 32'h43424140, 1'b1);
    be.id = 4'd5; be.resp = 2'b10;
    b_q.push_back(be);
    fork
      ar_send(4'd3, 32'h0000_0040, 8'd0);
      begin
        @(posedge clock);
        #1 aw_valid = 1; aw_id = 4'd5; aw_addr = 32'h0000_0100;
        @(posedge clock);
        #1 aw_valid = 0;
        check("aw_ready_after_aw", {31'h0, aw_ready}, 32'h0);
        @(posedge clock);
        #1 w_valid = 1; w_data = 32'hDEAD_BEEF; w_last = 0;
        @(posedge clock);
        #1 w_valid = 0;
        @(posedge clock);
        #1;
        check("b_valid_before_wlast", {31'h0, b_valid}, 32'h0);
        check("w_ready_before_wlast", {31'h0, w_ready}, 32'h1);
        @(posedge clock);
        #1 w_valid = 1; w_data = 32'hCAFE_F00D; w_last = 1;
        @(posedge clock);
        #1 w_valid = 0; w_last = 0;
        check("b_valid_after_wlast", {31'h0, b_valid}, 32'h1);
        check("w_ready_during_b", {31'h0, w_ready}, 32'h0);
      end
    join
    wait_drain();

    // Reset in the middle of the address phase, then a clean read.
    exp_fa = 24'h000100;
    ar_send(4'd6, 32'h0000_0100, 8'd0);
    repeat (60) @(posedge clock);
    #1 reset = 0;
    #1;
    check("midrst_cs", {31'h0, cs}, 32'h1);
    check("midrst_sck", {31'h0, sck}, 32'h0);
    check("midrst_ar_ready", {31'h0, ar_ready}, 32'h0);
    @(negedge clock);
    reset = 1;
    @(posedge clock);
    #1;
    check("midrst_rel_ar_ready", {31'h0, ar_ready}, 32'h1);
    exp_fa = 24'h000000;
    push_r(4'd0, 32'h03020100, 1'b1);
    ar_send(4'd0, 32'h0000_0000, 8'd0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_spi_flash_reader.md
AXI_SPI_FLASH_READER -- requirements
Module: axi_spi_flash_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: AXI address width.
REQ-002 Parameter ID_WIDTH, default 4: AXI ID width.
REQ-003 Parameter SCK_DIV, default 2 (min 1): system clocks per SCK half-period.
REQ-004 Parameter READ_CMD, default 8'h03: SPI read opcode.
REQ-005 Ports, in this order:
- clock, input, 1: single clock; all logic on its rising edge.
- reset, input, 1: asynchronous, active-low.
- io_s_axi_aw_*, AXI write-address slave channel:
  - aw_valid/aw_ready: 1 bit each.
  - aw_bits_id: ID_WIDTH.
  - aw_bits_addr: ADDR_WIDTH.
  - aw_bits_len: 8.
  - aw_bits_size: 3.
  - aw_bits_burst: 2.
- io_s_axi_w_*, write-data slave channel: w_valid/w_ready 1, w_bits_data 32, w_bits_strb 4, w_bits_last 1.
- io_s_axi_b_*, write-response slave channel: b_valid/b_ready 1, b_bits_id ID_WIDTH, b_bits_resp 2.
- io_s_axi_ar_*, read-address slave channel: same fields and widths as aw.
- io_s_axi_r_*, read-data slave channel:
  - r_valid/r_ready: 1 bit each.
  - r_bits_id: ID_WIDTH.
  - r_bits_data: 32.
  - r_bits_resp: 2.
  - r_bits_last: 1.
- io_qspi_cs, output, 1: flash chip select, active-low.
- io_qspi_sck, output, 1: SPI clock, mode 0.
- io_qspi_dq_0, output, 1: MOSI.
- io_qspi_dq_1, input, 1: MISO.

Function
REQ-006 Read FSM states: IDLE, CMD, ADDR, DATA, RESP, GAP.
REQ-007 ar_ready SHALL be 1 only in IDLE. When ar_valid&&ar_ready:
- latch id, addr[23:0] and len;
- go to CMD next cycle, with cs driven low that same cycle.
REQ-008 CMD shifts READ_CMD out MSB first (8 SCK). ADDR then shifts latched addr[23:0] out MSB first (24 SCK).
REQ-009 SPI mode 0:
- sck idles low;
- dq_0 changes only while sck is low;
- dq_1 is sampled on the system clock edge that raises sck;
- each sck level is held SCK_DIV clocks.
REQ-010 DATA shifts in 32 bits per beat. Flash bytes are packed little-endian: first byte received goes to r_bits_data[7:0], fourth to [31:24].
REQ-011 After the 32nd bit, go to RESP:
- r_valid=1, r_bits_id = latched id, r_bits_resp=2'b00;
- r_bits_last=1 iff this is beat len+1.
REQ-012 While r_valid&&!r_ready: r_data/r_id/r_last held stable, sck held low, cs held low.
REQ-013 On r_valid&&r_ready: if not last, return to DATA for the next beat with no new CMD/ADDR phase; if last, go to GAP.
REQ-014 GAP drives cs high for 2*SCK_DIV clocks, then returns to IDLE.
REQ-015 ar_bits_size and ar_bits_burst are ignored. Every beat is 4 bytes at incrementing flash addresses. Flash address wraps mod 2^24.
REQ-016 ar_bits_addr bits above 23 are ignored.
REQ-017 Write path is independent of the read FSM. It is read-only and returns an error:
- aw_ready=1 until an AW is captured; w_ready=1 until a W beat with w_bits_last is captured; the two may arrive in either order or together.
- Non-last W beats are accepted and discarded.
- Once both AW and the last W beat are captured: b_valid=1, b_bits_id=awid, b_bits_resp=2'b10 (SLVERR), held until b_ready.
- aw_ready and w_ready stay 0 while b_valid=1.
REQ-018 Simultaneous read and write traffic SHALL both progress with no ordering between them.

Reset
REQ-019 While reset=0, asynchronously:
- cs=1, sck=0, dq_0=0;
- ar_ready=0, aw_ready=0, w_ready=0;
- r_valid=0, b_valid=0;
- r_bits_data=0, r_bits_id=0, r_bits_last=0;
- FSM=IDLE, all counters 0.
REQ-020 Reset asserted mid-transaction abandons the transaction with no response. After release:
- ar_ready=1 on the first clock edge;
- aw_ready=1 and w_ready=1 on the first clock edge.

Verification
REQ-021 The bench SHALL use a flash model preloaded with byte[i]=i&0xFF and SCK_DIV=2.
REQ-022 Single read, ar_addr=0x2000_0000, len=0, r_ready=1 -> r_data=0x03020100, r_last=1, r_resp=0. cs is low for exactly 64 SCK periods plus the response cycle.
REQ-023 Single read, ar_addr=0x2000_0004, id=1 -> r_data=0x07060504, r_id=1.
REQ-024 Burst, addr=0x10, len=3 -> four beats 0x13121110, 0x17161514, 0x1B1A1918, 0x1F1E1D1C. Only the 4th beat has r_last=1. Exactly one CMD/ADDR phase occurs.
REQ-025 Same burst with r_ready held 0 for 20 cycles on beat 2 -> data unchanged while stalled, sck static low, remaining beats correct.
REQ-026 Write, AW at cycle 0 and W (last) at cycle 5 -> b_valid after W is accepted, b_resp=2'b10, b_id=awid. A concurrent read still returns correct data.
REQ-027 Reset pulsed during ADDR phase -> cs=1 immediately. A subsequent read at addr 0 returns 0x03020100.
